// File: rtl/line_extract.sv
// Recovers one line segment per frame from a raster-order pixel mask stream.
// Optional macro LINE_EXTRACT_SMOOTH_EN averages each published endpoint with the previous one.
module line_extract #(
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic        mask_in,
  input  logic        new_frame_in,
  output logic [10:0] x1_out,
  output logic [9:0]  y1_out,
  output logic [10:0] x2_out,
  output logic [9:0]  y2_out,
  output logic        line_active_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, PUBLISH} state_t;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_any;
  logic [10:0]      r_top_x, r_bot_x, r_left_x, r_right_x;
  logic [9:0]       r_top_y, r_bot_y, r_left_y, r_right_y;
  logic             w_hit;
  logic [10:0]      w_dx, w_dy;
  logic             w_steep, w_found;
  logic [10:0]      w_raw_x1, w_raw_x2, w_new_x1, w_new_x2;
  logic [9:0]       w_raw_y1, w_raw_y2, w_new_y1, w_new_y2;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ACCUM;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (new_frame_in) w_next = RESOLVE;
      RESOLVE: w_next = PUBLISH;
      PUBLISH: w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  // A hit coinciding with the frame boundary belongs to neither frame.
  assign w_hit = (r_state == ACCUM) && data_valid_in && mask_in && !new_frame_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || r_state == PUBLISH) begin
      r_count   <= '0;
      r_any     <= 1'b0;
      r_top_x   <= '0;
      r_top_y   <= '0;
      r_bot_x   <= '0;
      r_bot_y   <= '0;
      r_left_x  <= '0;
      r_left_y  <= '0;
      r_right_x <= '0;
      r_right_y <= '0;
    end else if (w_hit) begin
      if (r_count != '1) r_count <= r_count + 1'b1;
      r_any   <= 1'b1;
      r_bot_x <= hcount_in;
      r_bot_y <= vcount_in;
      if (!r_any) begin
        r_top_x   <= hcount_in;
        r_top_y   <= vcount_in;
        r_left_x  <= hcount_in;
        r_left_y  <= vcount_in;
        r_right_x <= hcount_in;
        r_right_y <= vcount_in;
      end else begin
        // Strict compares keep the earliest hit on ties.
        if (hcount_in < r_left_x) begin
          r_left_x <= hcount_in;
          r_left_y <= vcount_in;
        end
        if (hcount_in > r_right_x) begin
          r_right_x <= hcount_in;
          r_right_y <= vcount_in;
        end
      end
    end
  end

  assign w_dy     = {1'b0, r_bot_y} - {1'b0, r_top_y};
  assign w_dx     = r_right_x - r_left_x;
  assign w_steep  = (w_dy > w_dx);
  assign w_found  = (r_count >= MIN_CNT);
  assign w_raw_x1 = w_steep ? r_top_x : r_left_x;
  assign w_raw_y1 = w_steep ? r_top_y : r_left_y;
  assign w_raw_x2 = w_steep ? r_bot_x : r_right_x;
  assign w_raw_y2 = w_steep ? r_bot_y : r_right_y;

`ifdef LINE_EXTRACT_SMOOTH_EN
  logic [11:0] w_sum_x1, w_sum_x2;
  logic [10:0] w_sum_y1, w_sum_y2;
  assign w_sum_x1 = {1'b0, x1_out} + {1'b0, w_raw_x1};
  assign w_sum_y1 = {1'b0, y1_out} + {1'b0, w_raw_y1};
  assign w_sum_x2 = {1'b0, x2_out} + {1'b0, w_raw_x2};
  assign w_sum_y2 = {1'b0, y2_out} + {1'b0, w_raw_y2};
  assign w_new_x1 = line_active_out ? w_sum_x1[11:1] : w_raw_x1;
  assign w_new_y1 = line_active_out ? w_sum_y1[10:1] : w_raw_y1;
  assign w_new_x2 = line_active_out ? w_sum_x2[11:1] : w_raw_x2;
  assign w_new_y2 = line_active_out ? w_sum_y2[10:1] : w_raw_y2;
`else
  assign w_new_x1 = w_raw_x1;
  assign w_new_y1 = w_raw_y1;
  assign w_new_x2 = w_raw_x2;
  assign w_new_y2 = w_raw_y2;
`endif

  // Results are captured leaving RESOLVE so they and valid_out appear during PUBLISH.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x1_out          <= '0;
      y1_out          <= '0;
      x2_out          <= '0;
      y2_out          <= '0;
      line_active_out <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (r_state == RESOLVE) begin
        valid_out       <= 1'b1;
        line_active_out <= w_found;
        if (w_found) begin
          x1_out <= w_new_x1;
          y1_out <= w_new_y1;
          x2_out <= w_new_x2;
          y2_out <= w_new_y2;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_extract.sv
// Directed bench for line_extract: per-scenario tasks with inline checks.
module tb_line_extract;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in, mask_in, new_frame_in;
  logic [10:0] x1_out, x2_out;
  logic [9:0]  y1_out, y2_out;
  logic        line_active_out, valid_out;

  int checks = 0;
  int errors = 0;

  // Expected published state, maintained by expect_frame.
  logic [10:0] e_x1 = '0, e_x2 = '0;
  logic [9:0]  e_y1 = '0, e_y2 = '0;
  logic        e_act = 1'b0;

  // Values captured around one frame close.
  logic        v_pre, v_pub, v_post, oact;
  logic [10:0] ox1, ox2;
  logic [9:0]  oy1, oy2;

  always #5 clk_in = ~clk_in;

  line_extract dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_in(data_valid_in), .mask_in(mask_in), .new_frame_in(new_frame_in),
    .x1_out(x1_out), .y1_out(y1_out), .x2_out(x2_out), .y2_out(y2_out),
    .line_active_out(line_active_out), .valid_out(valid_out)
  );

  function automatic logic [10:0] sm(input logic [10:0] p, input logic [10:0] n, input logic pa);
    logic [11:0] s;
    s = {1'b0, p} + {1'b0, n};
`ifdef LINE_EXTRACT_SMOOTH_EN
    if (pa) return s[11:1];
`endif
    return n;
  endfunction

  task automatic expect_frame(input bit found, input int x1, input int y1, input int x2, input int y2);
    logic [10:0] t;
    if (found) begin
      e_x1 = sm(e_x1, 11'(x1), e_act);
      e_x2 = sm(e_x2, 11'(x2), e_act);
      t = sm({1'b0, e_y1}, 11'(y1), e_act); e_y1 = t[9:0];
      t = sm({1'b0, e_y2}, 11'(y2), e_act); e_y2 = t[9:0];
      e_act = 1'b1;
    end else begin
      e_act = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk_in);
    data_valid_in = 0; mask_in = 0; new_frame_in = 0;
    hcount_in = '0; vcount_in = '0;
  endtask

  task automatic hit(input int x, input int y);
    @(negedge clk_in);
    hcount_in = 11'(x); vcount_in = 10'(y);
    data_valid_in = 1; mask_in = 1; new_frame_in = 0;
  endtask

  task automatic masked_invalid(input int x, input int y);
    @(negedge clk_in);
    hcount_in = 11'(x); vcount_in = 10'(y);
    data_valid_in = 0; mask_in = 1; new_frame_in = 0;
  endtask

  // Pulses new_frame_in; optional hit in the same cycle and junk hits during RESOLVE/PUBLISH.
  task automatic close_frame(input bit coin_hit, input bit junk);
    @(negedge clk_in);
    new_frame_in = 1; data_valid_in = coin_hit; mask_in = coin_hit;
    hcount_in = 11'd0; vcount_in = 10'd0;
    @(negedge clk_in);
    new_frame_in = 0; data_valid_in = junk; mask_in = junk;
    hcount_in = 11'd7; vcount_in = 10'd3;
    v_pre = valid_out;
    @(negedge clk_in);
    v_pub = valid_out; oact = line_active_out;
    ox1 = x1_out; oy1 = y1_out; ox2 = x2_out; oy2 = y2_out;
    if (junk) new_frame_in = 1;
    @(negedge clk_in);
    data_valid_in = 0; mask_in = 0; new_frame_in = 0;
    v_post = valid_out;
  endtask

  task automatic test_reset();
    rst_in = 1; data_valid_in = 0; mask_in = 0; new_frame_in = 0;
    hcount_in = '0; vcount_in = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    checks++;
    if ({valid_out, line_active_out, x1_out, y1_out, x2_out, y2_out} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%b (%0d,%0d)-(%0d,%0d) want all 0",
               valid_out, line_active_out, x1_out, y1_out, x2_out, y2_out);
    end
  endtask

  task automatic test_empty_frame();
    close_frame(0, 0);
    expect_frame(0, 0, 0, 0, 0);
    checks++;
    if ({v_pre, v_pub, v_post} !== 3'b010) begin
      errors++; $display("FAIL empty_valid: got %b%b%b want 010", v_pre, v_pub, v_post);
    end
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL empty_out: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic gen_shallow(input int x0, input int y0);
    masked_invalid(0, 0);
    for (int x = x0; x <= x0 + 200; x++) hit(x, y0 + (x - x0) / 4);
  endtask

  task automatic test_shallow();
    gen_shallow(100, 200);
    close_frame(0, 1);
    expect_frame(1, 100, 200, 300, 250);
    checks++;
    if ({v_pre, v_pub, v_post} !== 3'b010) begin
      errors++; $display("FAIL shallow_valid: got %b%b%b want 010", v_pre, v_pub, v_post);
    end
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL shallow_out: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic test_steep();
    for (int y = 100; y <= 500; y++) hit(400 - (y - 100) / 20, y);
    close_frame(0, 0);
    expect_frame(1, 400, 100, 380, 500);
    checks++;
    if ({v_pre, v_pub, v_post} !== 3'b010) begin
      errors++; $display("FAIL steep_valid: got %b%b%b want 010", v_pre, v_pub, v_post);
    end
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL steep_out: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  // 15 hits plus one coincident with new_frame_in: must stay below the threshold.
  task automatic test_sparse();
    for (int i = 0; i < 15; i++) hit(50 + 3 * i, 300 + i);
    close_frame(1, 0);
    expect_frame(0, 0, 0, 0, 0);
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL sparse_hold: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic test_min_pixels();
    for (int x = 10; x <= 25; x++) hit(x, 50);
    close_frame(0, 0);
    expect_frame(1, 10, 50, 25, 50);
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL min_pixels: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic test_strict_ties();
    for (int y = 60; y <= 61; y++)
      for (int x = 10; x <= 25; x++) hit(x, y);
    close_frame(0, 0);
    expect_frame(1, 10, 60, 25, 60);
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL strict_ties: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  // Anti-diagonal with dx == dy: shallow path, LEFT=(10,25) RIGHT=(25,10).
  task automatic test_dxdy_tie();
    for (int y = 10; y <= 25; y++) hit(25 - (y - 10), y);
    close_frame(0, 0);
    expect_frame(1, 10, 25, 25, 10);
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL dxdy_tie: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic test_reset_resolve();
    logic seen_valid;
    for (int x = 30; x <= 50; x++) hit(x, 70);
    @(negedge clk_in);
    new_frame_in = 1; data_valid_in = 0; mask_in = 0;
    @(negedge clk_in);
    new_frame_in = 0; rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    seen_valid = valid_out;
    repeat (3) begin
      @(negedge clk_in);
      seen_valid = seen_valid | valid_out;
    end
    e_x1 = '0; e_y1 = '0; e_x2 = '0; e_y2 = '0; e_act = 1'b0;
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resolve_valid: got %b want 0", seen_valid);
    end
    checks++;
    if ({line_active_out, x1_out, y1_out, x2_out, y2_out} !== 42'd0) begin
      errors++;
      $display("FAIL reset_resolve_out: got a=%b (%0d,%0d)-(%0d,%0d) want all 0",
               line_active_out, x1_out, y1_out, x2_out, y2_out);
    end
    for (int x = 30; x <= 45; x++) hit(x, 80);
    close_frame(0, 0);
    expect_frame(1, 30, 80, 45, 80);
    checks++;
    if ({v_pre, v_pub, v_post} !== 3'b010) begin
      errors++; $display("FAIL after_reset_valid: got %b%b%b want 010", v_pre, v_pub, v_post);
    end
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {e_act, e_x1, e_y1, e_x2, e_y2}) begin
      errors++;
      $display("FAIL after_reset_out: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, e_act, e_x1, e_y1, e_x2, e_y2);
    end
  endtask

  task automatic test_back_to_back();
    logic [42:0] want_b;
    close_frame(0, 0);
    expect_frame(0, 0, 0, 0, 0);
    gen_shallow(100, 200);
    close_frame(0, 0);
    expect_frame(1, 100, 200, 300, 250);
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== {1'b1, 11'd100, 10'd200, 11'd300, 10'd250}) begin
      errors++;
      $display("FAIL frame_a: got a=%b (%0d,%0d)-(%0d,%0d) want a=1 (100,200)-(300,250)",
               oact, ox1, oy1, ox2, oy2);
    end
    gen_shallow(120, 210);
    close_frame(0, 0);
`ifdef LINE_EXTRACT_SMOOTH_EN
    want_b = {1'b1, 11'd110, 10'd205, 11'd310, 10'd255};
`else
    want_b = {1'b1, 11'd120, 10'd210, 11'd320, 10'd260};
`endif
    checks++;
    if ({oact, ox1, oy1, ox2, oy2} !== want_b) begin
      errors++;
      $display("FAIL frame_b: got a=%b (%0d,%0d)-(%0d,%0d) want a=%b (%0d,%0d)-(%0d,%0d)",
               oact, ox1, oy1, ox2, oy2, want_b[42], want_b[41:31], want_b[30:21],
               want_b[20:10], want_b[9:0]);
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_shallow();
    test_steep();
    test_sparse();
    test_min_pixels();
    test_strict_ties();
    test_dxdy_tie();
    test_reset_resolve();
    test_back_to_back();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_extract.md
Name: line_extract

Overview:
- Inverse of the line sprite renderer: consumes a thresholded pixel mask stream in raster order and recovers one line segment per frame.
- Outputs the segment's two endpoints plus a line-present flag, in the same x1/x2/y1/y2 form the line sprite accepts.
- Sits between the camera mask/threshold stage and the line sprite / game logic.
- Endpoints update once per frame on a single-cycle valid pulse.

Parameters:
- MIN_PIXELS, 16: minimum masked-pixel count for a frame to report a line.
- CNT_W, 20: width of the saturating pixel counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- hcount_in  input  11  pixel x of current sample
- vcount_in  input  10  pixel y of current sample
- data_valid_in  input  1  current sample is in the active area
- mask_in  input  1  current pixel belongs to the line
- new_frame_in  input  1  single-cycle pulse at the frame boundary, in blanking
- x1_out  output  11  first endpoint x
- y1_out  output  10  first endpoint y
- x2_out  output  11  second endpoint x
- y2_out  output  10  second endpoint y
- line_active_out  output  1  a line was detected in the last completed frame
- valid_out  output  1  one-cycle pulse when the outputs are updated

Behaviour:
- States: ACCUM, RESOLVE, PUBLISH. Reset enters ACCUM.
- Reset clears all accumulators and drives every output to 0.
- Reset mid-RESOLVE or mid-PUBLISH aborts the frame with no valid_out.

ACCUM (a "hit" is data_valid_in && mask_in):
- count increments on each hit and saturates at 2^CNT_W-1.
- TOP(x,y): first hit of the frame. BOT(x,y): updated on every hit, so it holds the last hit.
- LEFT(x,y): updated when hcount_in < LEFT.x (strict compare, so ties keep the earliest hit).
- RIGHT(x,y): updated when hcount_in > RIGHT.x (strict compare, so ties keep the earliest hit).
- The first hit of a frame initialises all four extremes.
- new_frame_in moves ACCUM to RESOLVE. A hit in the same cycle as new_frame_in is dropped (counted in neither frame).

RESOLVE (1 cycle):
- dy = BOT.y - TOP.y, dx = RIGHT.x - LEFT.x, both unsigned 11-bit.
- steep = (dy > dx). A tie counts as shallow.
- found = (count >= MIN_PIXELS).

PUBLISH (1 cycle), then return to ACCUM with the accumulators cleared:
- If found and steep: (x1,y1) = TOP, (x2,y2) = BOT, so y1 <= y2.
- If found and shallow: (x1,y1) = LEFT, (x2,y2) = RIGHT, so x1 <= x2.
- If not found: endpoint outputs hold their previous values and line_active_out goes to 0.
- Outputs are registered. valid_out is high only in this cycle.
- Latency: new_frame_in asserted at cycle N gives updated outputs and valid_out at cycle N+2.

Other rules:
- new_frame_in and hits are ignored in RESOLVE and PUBLISH.
- Samples with data_valid_in = 0 are ignored in all states.
- Single-pixel frame (if MIN_PIXELS allows it): dx = dy = 0, shallow, both endpoints equal that pixel.
- An empty frame always reports line_active_out = 0.

Optional Feature:
- Macro: LINE_EXTRACT_SMOOTH_EN.
- Defined: in PUBLISH, when found and the previous line_active_out = 1, each endpoint coordinate = (previous + new) >> 1.
  - Sums use 1 extra bit, truncating shift.
  - If the previous frame had no line, the raw values are published.
  - Latency unchanged. The steep/shallow ordering rule applies to the raw values before averaging.
- Undefined: raw endpoints are published every frame. No extra registers.

Test Plan:
- Reset then one new_frame_in with no hits -> valid_out pulses 2 cycles later; line_active_out = 0; all endpoints = 0.
- Shallow line, hits at (100,200)..(300,250) via Bresenham, 201 pixels, then new_frame_in -> x1=100, y1=200, x2=300, y2=250, line_active_out = 1.
- Steep line, hits from (400,100) to (380,500), 401 pixels -> TOP/BOT path: x1=400, y1=100, x2=380, y2=500.
- 10 isolated hits (below MIN_PIXELS=16) after a valid frame -> line_active_out = 0, endpoints hold the previous frame's values; a hit coincident with new_frame_in is not counted.
- Assert rst_in in the RESOLVE cycle -> no valid_out, outputs 0; next full frame reports normally.
- With LINE_EXTRACT_SMOOTH_EN: frame A (100,200)-(300,250), then frame B (120,210)-(320,260) -> published (110,205)-(310,255). Without the macro -> B's values are published raw.
